// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, divider width and
// frame-size constants used by the UART receive blocks.
package uart_pkg;

  localparam int BAUD_W       = 16;
  localparam int DATA_W_DEF   = 8;
  localparam int BAUD_DIV_MIN = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Mid-bit sample point for a bit period of div+1 cycles.
  function automatic logic [BAUD_W-1:0] sample_pt(input logic [BAUD_W-1:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line, plus a
// falling-edge strobe on the synchronized value.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rstn,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // All flops reset high so a released reset never looks like a falling edge.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign dout = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start/data/parity/stop sequencing with a one-entry
// receive buffer and sticky parity, framing and overrun flags.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              uart_rx,
  input  logic              rx_en,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              rx_rd,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_ovf,
  output logic              rx_int
);

  localparam int              NB_W     = $clog2(DATA_W + 1);
  localparam logic [NB_W-1:0] LAST_BIT = NB_W'(DATA_W);

  logic rxs, rx_fall;

  uart_rx_sync u_sync (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .din      (uart_rx),
    .dout     (rxs),
    .fall     (rx_fall)
  );

  rx_state_e         state_q;
  logic [BAUD_W-1:0] cnt_q, div_q;
  logic [NB_W-1:0]   nbit_q;
  logic [DATA_W-1:0] shift_q;
  logic              perr_pend_q;

  logic at_smp, at_bnd, done;
  logic perr_evt, ferr_evt, ovf_evt;

  assign at_smp = (cnt_q == sample_pt(div_q));
  assign at_bnd = (cnt_q == div_q);

  // The stop sample completes the frame; the buffer updates on this edge.
  assign done     = rx_en && (state_q == RX_STOP) && at_smp;
  assign ferr_evt = done && !rxs;
  assign perr_evt = done && perr_pend_q;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      nbit_q      <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
    end else if (!rx_en) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
    end else begin
      cnt_q <= at_bnd ? '0 : cnt_q + BAUD_W'(1);
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rx_fall) begin
            state_q     <= RX_START;
            div_q       <= baud_div;
            nbit_q      <= '0;
            perr_pend_q <= 1'b0;
          end
        end
        RX_START: begin
          if (at_smp && rxs)
            state_q <= RX_IDLE;
          else if (at_bnd)
            state_q <= RX_DATA;
        end
        RX_DATA: begin
          if (at_smp) begin
            shift_q <= {rxs, shift_q[DATA_W-1:1]};
            nbit_q  <= nbit_q + NB_W'(1);
          end
          if (at_bnd && nbit_q == LAST_BIT)
            state_q <= parity_en ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: begin
          // Received bit must equal XOR of data, inverted for odd parity.
          if (at_smp)
            perr_pend_q <= rxs ^ (^shift_q) ^ parity_odd;
          if (at_bnd)
            state_q <= RX_STOP;
        end
        RX_STOP: begin
          if (at_smp)
            state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] rxbuf_q, rxbuf_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

  assign ovf_evt = done && valid_q && !rx_rd;

  // Error events win over a simultaneous clear.
  always_comb begin
    rxbuf_d = rxbuf_q;
    valid_d = valid_q;
    if (done) begin
      rxbuf_d = shift_q;
      valid_d = 1'b1;
    end else if (rx_rd) begin
      valid_d = 1'b0;
    end
    perr_d = (perr_q & ~err_clr) | perr_evt;
    ferr_d = (ferr_q & ~err_clr) | ferr_evt;
    ovf_d  = (ovf_q  & ~err_clr) | ovf_evt;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rxbuf_q <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rxbuf_q <= rxbuf_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rx_data  = rxbuf_q;
  assign rx_valid = valid_q;
  assign rx_perr  = perr_q;
  assign rx_ferr  = ferr_q;
  assign rx_ovf   = ovf_q;
  assign rx_int   = valid_q | perr_q | ferr_q | ovf_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frame scenarios, then randomized frames
// checked by a scoreboard monitor that reads each byte as it lands.
module tb_uart_rx_frame;

  localparam int DW = 8;

  logic          sys_clk    = 1'b0;
  logic          sys_rstn   = 1'b0;
  logic          uart_rx    = 1'b1;
  logic          rx_en      = 1'b0;
  logic [15:0]   baud_div   = 16'd15;
  logic          parity_en  = 1'b0;
  logic          parity_odd = 1'b0;
  logic          drv_rd = 1'b0, mon_rd = 1'b0, drv_clr = 1'b0, mon_clr = 1'b0;
  logic          rx_rd, err_clr;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_perr, rx_ferr, rx_ovf, rx_int;

  assign rx_rd   = drv_rd | mon_rd;
  assign err_clr = drv_clr | mon_clr;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;
  exp_t exp_q[$];

  always #5 sys_clk = ~sys_clk;

  uart_rx_frame #(.DATA_W(DW)) dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .uart_rx    (uart_rx),
    .rx_en      (rx_en),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_rd      (rx_rd),
    .err_clr    (err_clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_perr    (rx_perr),
    .rx_ferr    (rx_ferr),
    .rx_ovf     (rx_ovf),
    .rx_int     (rx_int)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Serial frame: start, DW data bits LSB first, optional parity, stop.
  task automatic send_frame(input logic [DW-1:0] d, input int div, input logic has_par,
                            input logic par_bit, input logic stop_bit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    foreach (bits[i]) begin
      uart_rx = bits[i];
      tick(div + 1);
    end
  endtask

  task automatic pulse_rd();
    drv_rd = 1'b1;
    tick(1);
    drv_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    drv_clr = 1'b1;
    tick(1);
    drv_clr = 1'b0;
  endtask

  task automatic chk_all(input string name, input logic [DW-1:0] d, input logic v,
                         input logic pe, input logic fe, input logic ov);
    chk8({name, " data"}, rx_data, d);
    chk1({name, " valid"}, rx_valid, v);
    chk1({name, " perr"}, rx_perr, pe);
    chk1({name, " ferr"}, rx_ferr, fe);
    chk1({name, " ovf"}, rx_ovf, ov);
    chk1({name, " int"}, rx_int, v | pe | fe | ov);
  endtask

  // Scoreboard monitor: every byte presented is popped, compared, read and cleared.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (mon_en && rx_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got byte 0x%02h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk8("sb data", rx_data, e.data);
          chk1("sb perr", rx_perr, e.perr);
          chk1("sb ferr", rx_ferr, e.ferr);
          chk1("sb ovf", rx_ovf, 1'b0);
        end
        mon_rd  = 1'b1;
        mon_clr = 1'b1;
        @(negedge sys_clk);
        mon_rd  = 1'b0;
        mon_clr = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sys_rstn = 1'b1;
    rx_en    = 1'b1;
    tick(3);

    // Basic frame with exact completion timing at div 15
    baud_div = 16'd15;
    fork
      send_frame(8'hAC, 15, 1'b0, 1'b0, 1'b1);
      begin
        tick(154);
        chk1("t034 valid before", rx_valid, 1'b0);
        tick(1);
        chk1("t034 valid after", rx_valid, 1'b1);
      end
    join
    chk_all("t034", 8'hAC, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_rd();
    chk1("t034 read clears valid", rx_valid, 1'b0);

    // Even parity, 0x73 has five ones so the good parity bit is 1
    baud_div  = 16'd6;
    parity_en = 1'b1;
    send_frame(8'h73, 6, 1'b1, 1'b1, 1'b1);
    chk_all("t035 good", 8'h73, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_rd();
    send_frame(8'h73, 6, 1'b1, 1'b0, 1'b1);
    chk_all("t035 bad", 8'h73, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_rd();
    tick(20);
    chk1("t035 perr sticky", rx_perr, 1'b1);
    pulse_clr();
    chk1("t035 perr cleared", rx_perr, 1'b0);
    parity_en = 1'b0;

    // False start: glitch shorter than half a bit
    baud_div = 16'd15;
    uart_rx  = 1'b0;
    tick(5);
    uart_rx  = 1'b1;
    tick(40);
    chk_all("t036 glitch", 8'h73, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 15, 1'b0, 1'b0, 1'b1);
    chk_all("t036 after", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_rd();

    // Overrun, then read coincident with completion
    send_frame(8'h11, 15, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 15, 1'b0, 1'b0, 1'b1);
    chk_all("t037 ovf", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    drv_rd  = 1'b1;
    drv_clr = 1'b1;
    tick(1);
    drv_rd  = 1'b0;
    drv_clr = 1'b0;
    chk_all("t037 cleared", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 15, 1'b0, 1'b0, 1'b1);
    fork
      send_frame(8'h22, 15, 1'b0, 1'b0, 1'b1);
      begin
        tick(154);
        drv_rd = 1'b1;
        tick(1);
        drv_rd = 1'b0;
      end
    join
    chk_all("t037 rd+done", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_rd();

    // Framing error, stuck-low line, recovery
    send_frame(8'h55, 15, 1'b0, 1'b0, 1'b0);
    chk_all("t038 ferr", 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_rd();
    tick(400);
    chk1("t038 stuck low no frame", rx_valid, 1'b0);
    uart_rx = 1'b1;
    tick(20);
    pulse_clr();
    send_frame(8'h0F, 15, 1'b0, 1'b0, 1'b1);
    chk_all("t038 recover", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

    // rx_en dropped during data bit 3: partial frame discarded
    fork
      send_frame(8'h9A, 15, 1'b0, 1'b0, 1'b1);
      begin
        tick(72);
        rx_en = 1'b0;
      end
    join
    tick(5);
    chk_all("t039 en drop", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_rd();
    rx_en = 1'b1;
    tick(3);
    send_frame(8'h9A, 15, 1'b0, 1'b0, 1'b1);
    chk_all("t039 en next", 8'h9A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during data bit 3
    fork
      send_frame(8'h9A, 15, 1'b0, 1'b0, 1'b1);
      begin
        tick(72);
        sys_rstn = 1'b0;
        tick(2);
        chk_all("t039 rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    join
    sys_rstn = 1'b1;
    tick(3);
    send_frame(8'h9A, 15, 1'b0, 1'b0, 1'b1);
    chk_all("t039 rst next", 8'h9A, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_rd();
    tick(5);

    // Randomized frames checked by the scoreboard
    mon_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int            div;
      logic [DW-1:0] d;
      logic          pe, po, bad_par, stop_ok, pbit;
      exp_t          e;
      div     = $urandom_range(3, 20);
      d       = DW'($urandom);
      pe      = 1'($urandom_range(0, 1));
      po      = 1'($urandom_range(0, 1));
      bad_par = pe && ($urandom_range(0, 3) == 0);
      stop_ok = ($urandom_range(0, 4) != 0);
      pbit    = (^d) ^ po ^ bad_par;
      baud_div   = 16'(div);
      parity_en  = pe;
      parity_odd = po;
      e.data = d;
      e.perr = bad_par;
      e.ferr = !stop_ok;
      exp_q.push_back(e);
      send_frame(d, div, pe, pbit, stop_ok);
      uart_rx = 1'b1;
      tick(stop_ok ? $urandom_range(0, 5) : div + 1 + $urandom_range(0, 5));
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb drain: got %0d pending expected 0", exp_q.size());
    end
    tick(5);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
